// File: rtl/multi_rr_scheduler.sv
// Round-robin front end sharing one start/done compute unit among NUM_REQ requesters.
// One operation in flight; a watchdog aborts with resp_err if unit_done never arrives.
module multi_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     unit_start,
  output logic [WIDTH-1:0]         unit_inp,
  input  logic                     unit_done,
  input  logic [WIDTH-1:0]         unit_out,
  output logic                     busy,
  output logic                     spurious
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_last, tag, grant, cand;
  logic             any_req;
  logic [7:0]       wait_cnt;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;

  // Scan from farthest to nearest so the candidate just after rr_last wins.
  always_comb begin
    grant   = rr_last;
    any_req = 1'b0;
    cand    = rr_last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((int'(rr_last) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    unit_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready = ONE << grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        unit_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (unit_done || wait_cnt == TO_LAST) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = ONE << tag;
        resp_data  = cap_data;
        resp_err   = cap_err;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= IW'(NUM_REQ - 1);
      tag      <= '0;
      unit_inp <= '0;
      wait_cnt <= '0;
      cap_data <= '0;
      cap_err  <= 1'b0;
      spurious <= 1'b0;
    end else begin
      state <= state_nxt;
      // A done outside WAIT is either a late completion after abort or a unit fault.
      if (unit_done && (state == IDLE || state == ISSUE)) spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            unit_inp <= req_data[grant*WIDTH +: WIDTH];
            tag      <= grant;
            rr_last  <= grant;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          if (unit_done) begin
            cap_data <= unit_out;
            cap_err  <= 1'b0;
          end else if (wait_cnt == TO_LAST) begin
            cap_data <= '0;
            cap_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_rr_scheduler.sv
// Directed bench for multi_rr_scheduler: reset, fairness, timeout, collision, mid-op reset, wrap.
module tb_multi_rr_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic         unit_start;
  logic [31:0]  unit_inp;
  logic         unit_done;
  logic [31:0]  unit_out;
  logic         busy;
  logic         spurious;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] D0 = 32'h1234_5678;
  localparam logic [31:0] D1 = 32'hA1A1_A1A1;
  localparam logic [31:0] D2 = 32'hB2B2_B2B2;
  localparam logic [31:0] D3 = 32'hC3C3_C3C3;

  multi_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .unit_start (unit_start),
    .unit_inp   (unit_inp),
    .unit_done  (unit_done),
    .unit_out   (unit_out),
    .busy       (busy),
    .spurious   (spurious)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in a post-negedge window while the DUT is IDLE; returns in the next IDLE window.
  task automatic run_op(input string tag, input logic [3:0] rv, input logic [3:0] exp_g,
                        input logic [31:0] opnd, input int d, input logic done_on,
                        input logic [31:0] uout, input logic [31:0] exp_data,
                        input logic exp_err);
    req_valid = rv;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_g));
    @(negedge clock); #1;
    chk({tag, ".start"}, 32'(unit_start), 32'd1);
    chk({tag, ".inp"}, unit_inp, opnd);
    chk({tag, ".ready_issue"}, 32'(req_ready), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= d; k++) begin
      @(negedge clock);
      if (done_on && k == d) begin
        unit_done = 1'b1;
        unit_out  = uout;
      end
      #1;
      chk({tag, ".wait_resp"}, 32'(resp_valid), 32'd0);
      chk({tag, ".wait_start"}, 32'(unit_start), 32'd0);
    end
    @(negedge clock);
    unit_done = 1'b0;
    unit_out  = '0;
    #1;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(exp_g));
    chk({tag, ".resp_data"}, resp_data, exp_data);
    chk({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    @(negedge clock);
    req_valid = '0;
    #1;
    chk({tag, ".after_resp"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    req_valid = '0;
    unit_done = 1'b0;
    unit_out  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    req_data = {D3, D2, D1, D0};
    @(negedge clock);
    reset_dut();

    // 1: reset state and single operation with D=1
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_data", resp_data, 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.unit_start", 32'(unit_start), 32'd0);
    chk("rst.unit_inp", unit_inp, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.spurious", 32'(spurious), 32'd0);
    run_op("t1", 4'b0001, 4'b0001, D0, 1, 1'b1, D0, D0, 1'b0);

    // 2: fairness from a fresh reset, all requesters held
    reset_dut();
    run_op("fair0", 4'b1111, 4'b0001, D0, 2, 1'b1, D0, D0, 1'b0);
    run_op("fair1", 4'b1111, 4'b0010, D1, 1, 1'b1, D1, D1, 1'b0);
    run_op("fair2", 4'b1111, 4'b0100, D2, 3, 1'b1, D2, D2, 1'b0);
    run_op("fair3", 4'b1111, 4'b1000, D3, 1, 1'b1, D3, D3, 1'b0);
    run_op("fair4", 4'b1111, 4'b0001, D0, 2, 1'b1, D0, D0, 1'b0);

    // 3: timeout abort, then late done in IDLE
    run_op("tmo", 4'b0100, 4'b0100, D2, 15, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("tmo.spurious_before", 32'(spurious), 32'd0);
    unit_done = 1'b1;
    unit_out  = 32'hDEAD_BEEF;
    @(negedge clock);
    unit_done = 1'b0;
    #1;
    chk("late.spurious", 32'(spurious), 32'd1);
    chk("late.resp_valid", 32'(resp_valid), 32'd0);
    chk("late.busy", 32'(busy), 32'd0);
    @(negedge clock); #1;
    chk("late.resp_valid2", 32'(resp_valid), 32'd0);

    // 4: done arriving on the last WAIT cycle beats the timeout
    run_op("coll", 4'b1000, 4'b1000, D3, 15, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    chk("coll.spurious_sticky", 32'(spurious), 32'd1);

    // 5: reset during WAIT
    req_valid = 4'b0010;
    #1;
    chk("rstw.ready", 32'(req_ready), 32'b0010);
    @(negedge clock);
    req_valid = '0;
    #1;
    chk("rstw.start", 32'(unit_start), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rstw.busy", 32'(busy), 32'd0);
    chk("rstw.resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw.unit_start", 32'(unit_start), 32'd0);
    chk("rstw.unit_inp", unit_inp, 32'd0);
    chk("rstw.spurious", 32'(spurious), 32'd0);
    @(negedge clock); #1;
    chk("rstw.resp_valid2", 32'(resp_valid), 32'd0);
    run_op("rstw_rr", 4'b1010, 4'b0010, D1, 2, 1'b1, D1, D1, 1'b0);

    // 6: rotation wrap and skip from rr_last=1
    run_op("wrap", 4'b0001, 4'b0001, D0, 1, 1'b1, D0, D0, 1'b0);
    run_op("skip", 4'b1001, 4'b1000, D3, 3, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
